muldiv_unit: RTL and testbench

- Iterative 32-cycle multiply/divide execution unit.
- Consumes operands read from the register file (busA, busB) and produces a single write-back request (RegWr, Rw, busW) toward the register file.
- Issue: start/busy handshake. Completion: one-cycle done pulse.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 56 +++++
 rtl/muldiv_unit.sv | 257 +++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding and the divide-by-zero quotient constant.
// No ports (package).
// -----------------------------------------------------------------------------
package muldiv_pkg;

   // op[1:0] encodings
   localparam logic [1:0] OP_MUL  = 2'b00;  // low word of product
   localparam logic [1:0] OP_MULH = 2'b01;  // high word of product
   localparam logic [1:0] OP_DIV  = 2'b10;  // quotient
   localparam logic [1:0] OP_REM  = 2'b11;  // remainder

   // op[2] selects signed operands (only honoured with MULDIV_SIGNED_EN)
   localparam int OP_SIGNED_BIT = 2;
   // op[1] distinguishes divide family from multiply family
   localparam int OP_DIV_BIT    = 1;

   // Quotient returned on divide by zero, signed or unsigned
   localparam logic [31:0] DIVZERO_Q = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single-iteration datapath shared by multiply and divide.
//   acc      : 2*DATA_WIDTH accumulator (multiply) / {remainder, dividend} (divide)
//   operand  : multiplicand (multiply) / divisor (divide)
//   div_mode : 1 = restoring-division step, 0 = shift-add multiply step
//   acc_next : accumulator after this iteration; in divide mode the LSB is
//              left at 0 and the quotient bit is reported separately
//   q_bit    : quotient bit produced by this divide step (0 in multiply mode)
// -----------------------------------------------------------------------------
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2*DATA_WIDTH-1:0] acc,
   input  logic [DATA_WIDTH-1:0]   operand,
   input  logic                    div_mode,
   output logic [2*DATA_WIDTH-1:0] acc_next,
   output logic                    q_bit
);

   localparam int W = DATA_WIDTH;

   logic [W:0]   sum_s;     // high half plus multiplicand, carry kept
   logic [W:0]   rem_sh_s;  // partial remainder shifted left, pulling next dividend bit
   logic         ge_s;      // trial subtraction succeeds
   logic [W-1:0] sub_s;     // trial remainder; true result always fits W bits when ge_s

   assign sum_s    = {1'b0, acc[2*W-1:W]} + {1'b0, operand};
   assign rem_sh_s = acc[2*W-1:W-1];
   assign ge_s     = (rem_sh_s >= {1'b0, operand});
   assign sub_s    = rem_sh_s[W-1:0] - operand;

   // One iteration of either shift-add multiply or restoring divide
   always_comb begin
      acc_next = acc;
      q_bit    = 1'b0;
      if (div_mode) begin
         q_bit = ge_s;
         if (ge_s) begin
            acc_next = {sub_s, acc[W-2:0], 1'b0};
         end else begin
            acc_next = {rem_sh_s[W-1:0], acc[W-2:0], 1'b0};
         end
      end else begin
         q_bit = 1'b0;
         if (acc[0]) begin
            acc_next = {sum_s, acc[W-1:1]};
         end else begin
            acc_next = {1'b0, acc[2*W-1:1]};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide execution unit, fixed 33-cycle latency from an
// accepted start to the one-cycle done / write-back pulse.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start, op, rd      : issue request (sampled only while idle), operation,
//                        destination register
//   busA, busB         : multiplicand/dividend, multiplier/divisor
//   busy, done         : handshake status (registered)
//   wb_RegWr, wb_Rw,
//   wb_busW            : register-file write-back request (registered)
// Configuration macro:
//   MULDIV_SIGNED_EN   : when defined, op[2] selects signed operands; when
//                        undefined all operations are unsigned and no
//                        magnitude / sign-correction logic exists.
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0] busA,
   input  logic [DATA_WIDTH-1:0] busB,
   output logic                  busy,
   output logic                  done,
   output logic                  wb_RegWr,
   output logic [ADDR_WIDTH-1:0] wb_Rw,
   output logic [DATA_WIDTH-1:0] wb_busW
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [W-1:0]     DIVZERO_W = W'(DIVZERO_Q);

   state_t              state_r;
   state_t              state_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [2*W-1:0]      acc_r;
   logic [W-1:0]        operand_r;
   logic [1:0]          op_r;
   logic [ADDR_WIDTH-1:0] rd_r;

   logic                busy_r;
   logic                done_r;
   logic [W-1:0]        res_r;
   logic [ADDR_WIDTH-1:0] rw_r;

   logic                busy_s;
   logic                done_s;
   logic                capture_s;
   logic                last_s;

   logic [W-1:0]        mag_a_s;
   logic [W-1:0]        mag_b_s;

   logic [2*W-1:0]      step_acc_s;
   logic                step_q_s;
   logic [2*W-1:0]      acc_d_s;

   logic [2*W-1:0]      prod_s;
   logic [W-1:0]        quo_raw_s;
   logic [W-1:0]        quo_s;
   logic [W-1:0]        rem_s;
   logic [W-1:0]        result_s;

   // ---------------------------------------------------------------------
   // Operand conditioning: magnitudes and result signs
   // ---------------------------------------------------------------------
`ifdef MULDIV_SIGNED_EN
   logic sgn_a_s;
   logic sgn_b_s;
   logic sgn_a_r;    // remainder takes the dividend's sign
   logic neg_res_r;  // product and quotient sign

   assign sgn_a_s = op[OP_SIGNED_BIT] & busA[W-1];
   assign sgn_b_s = op[OP_SIGNED_BIT] & busB[W-1];
   assign mag_a_s = sgn_a_s ? ({W{1'b0}} - busA) : busA;
   assign mag_b_s = sgn_b_s ? ({W{1'b0}} - busB) : busB;

   // Sign flags captured alongside the operands
   always_ff @(posedge clk) begin
      if (reset) begin
         sgn_a_r   <= 1'b0;
         neg_res_r <= 1'b0;
      end else if (capture_s) begin
         sgn_a_r   <= sgn_a_s;
         neg_res_r <= sgn_a_s ^ sgn_b_s;
      end else begin
         sgn_a_r   <= sgn_a_r;
         neg_res_r <= neg_res_r;
      end
   end
`else
   logic unused_op_sign_s;

   assign unused_op_sign_s = op[OP_SIGNED_BIT];
   assign mag_a_s          = busA;
   assign mag_b_s          = busB;
`endif

   // ---------------------------------------------------------------------
   // FSM: state register / next state / control decode
   // ---------------------------------------------------------------------

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; start is only looked at while idle
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Control decode; busy/done are next-cycle values fed to output registers
   always_comb begin
      busy_s    = (state_s != IDLE);
      done_s    = (state_s == DONE);
      capture_s = (state_r == IDLE) && start;
      last_s    = (state_r == RUN) && (cnt_r == CNT_ZERO);
   end

   // ---------------------------------------------------------------------
   // Iteration datapath
   // ---------------------------------------------------------------------
   muldiv_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .acc      (acc_r),
      .operand  (operand_r),
      .div_mode (op_r[OP_DIV_BIT]),
      .acc_next (step_acc_s),
      .q_bit    (step_q_s)
   );

   // Quotient bit shifts into the vacated LSB; q_bit is 0 for multiply
   assign acc_d_s = {step_acc_s[2*W-1:1], step_acc_s[0] | step_q_s};

   // Capture on issue, iterate while running
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r     <= {(2*W){1'b0}};
         operand_r <= {W{1'b0}};
         op_r      <= 2'b00;
         rd_r      <= {ADDR_WIDTH{1'b0}};
         cnt_r     <= CNT_ZERO;
      end else if (capture_s) begin
         // divide: accumulator holds the dividend, operand is the divisor;
         // multiply: accumulator holds the multiplier, operand the multiplicand
         if (op[OP_DIV_BIT]) begin
            acc_r     <= {{W{1'b0}}, mag_a_s};
            operand_r <= mag_b_s;
         end else begin
            acc_r     <= {{W{1'b0}}, mag_b_s};
            operand_r <= mag_a_s;
         end
         op_r  <= op[1:0];
         rd_r  <= rd;
         cnt_r <= CNT_LOAD;
      end else if (state_r == RUN) begin
         acc_r <= acc_d_s;
         cnt_r <= cnt_r - CNT_ONE;
      end else begin
         acc_r <= acc_r;
         cnt_r <= cnt_r;
      end
   end

   // ---------------------------------------------------------------------
   // Result formation from the final iteration's accumulator, so the
   // sign-corrected value is registered by the time DONE is visible
   // ---------------------------------------------------------------------
`ifdef MULDIV_SIGNED_EN
   assign prod_s    = neg_res_r ? ({(2*W){1'b0}} - acc_d_s) : acc_d_s;
   assign quo_raw_s = neg_res_r ? ({W{1'b0}} - acc_d_s[W-1:0]) : acc_d_s[W-1:0];
   assign rem_s     = sgn_a_r ? ({W{1'b0}} - acc_d_s[2*W-1:W]) : acc_d_s[2*W-1:W];
`else
   assign prod_s    = acc_d_s;
   assign quo_raw_s = acc_d_s[W-1:0];
   assign rem_s     = acc_d_s[2*W-1:W];
`endif

   // Division by zero forces an all-ones quotient regardless of sign; the
   // remainder already equals the captured dividend in that case
   assign quo_s = (operand_r == {W{1'b0}}) ? DIVZERO_W : quo_raw_s;

   // Select the word requested by the operation
   always_comb begin
      result_s = prod_s[W-1:0];
      case (op_r)
         OP_MUL:  result_s = prod_s[W-1:0];
         OP_MULH: result_s = prod_s[2*W-1:W];
         OP_DIV:  result_s = quo_s;
         OP_REM:  result_s = rem_s;
         default: result_s = prod_s[W-1:0];
      endcase
   end

   // Output registers; write-back data holds until the next completion
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         res_r  <= {W{1'b0}};
         rw_r   <= {ADDR_WIDTH{1'b0}};
      end else begin
         busy_r <= busy_s;
         done_r <= done_s;
         if (last_s) begin
            res_r <= result_s;
            rw_r  <= rd_r;
         end else begin
            res_r <= res_r;
            rw_r  <= rw_r;
         end
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign wb_RegWr = done_r;
   assign wb_Rw    = rw_r;
   assign wb_busW  = res_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit. Expected values are
// hand-computed; entries that depend on MULDIV_SIGNED_EN are selected by the
// same macro.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [4:0]  rd;
   logic [31:0] busA;
   logic [31:0] busB;
   logic        busy;
   logic        done;
   logic        wb_RegWr;
   logic [4:0]  wb_Rw;
   logic [31:0] wb_busW;

   int total_cnt;
   int bad_cnt;

   muldiv_unit #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .rd       (rd),
      .busA     (busA),
      .busB     (busB),
      .busy     (busy),
      .done     (done),
      .wb_RegWr (wb_RegWr),
      .wb_Rw    (wb_Rw),
      .wb_busW  (wb_busW)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total_cnt++;
      if (obs !== exp_v) begin
         bad_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   // Issue one operation in cycle 0 and observe cycles 1..34.
   // extra_cyc != 0 pulses a second start during that cycle of the operation.
   task automatic run_op(input string tag, input logic [2:0] op_v, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd_v,
                         input logic [31:0] exp_v, input int extra_cyc);
      int          done_cnt;
      int          done_cyc;
      int          busy_cnt;
      int          wr_cnt;
      int          wr_neq;
      logic        busy_at_34;
      logic [31:0] res_seen;
      logic [31:0] rw_seen;
      done_cnt = 0;
      done_cyc = 0;
      busy_cnt = 0;
      wr_cnt   = 0;
      wr_neq   = 0;
      res_seen = 32'h0;
      rw_seen  = 32'h0;
      busy_at_34 = 1'b1;
      @(negedge clk);
      start = 1'b1;
      op    = op_v;
      busA  = a;
      busB  = b;
      rd    = rd_v;
      @(posedge clk);
      #1;
      start = 1'b0;
      // scramble inputs so the unit must rely on what it captured
      busA = 32'hDEAD_BEEF;
      busB = 32'h1234_5678;
      rd   = 5'd31;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         if (k == extra_cyc) begin
            start = 1'b1;
            op    = 3'b000;
            rd    = 5'd9;
         end else begin
            start = 1'b0;
         end
         if (busy && (k <= 33)) busy_cnt++;
         if (k == 34) busy_at_34 = busy;
         if (done) begin
            done_cnt++;
            done_cyc = k;
            res_seen = wb_busW;
            rw_seen  = {27'd0, wb_Rw};
         end
         if (wb_RegWr) wr_cnt++;
         if (wb_RegWr !== done) wr_neq++;
      end
      start = 1'b0;
      check_val({tag, ".done_cyc"}, 32'(done_cyc), 32'd33);
      check_val({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
      check_val({tag, ".regwr_cnt"}, 32'(wr_cnt), 32'd1);
      check_val({tag, ".regwr_eq_done"}, 32'(wr_neq), 32'd0);
      check_val({tag, ".busy_cyc"}, 32'(busy_cnt), 32'd33);
      check_val({tag, ".busy34"}, {31'd0, busy_at_34}, 32'd0);
      check_val({tag, ".busW"}, res_seen, exp_v);
      check_val({tag, ".Rw"}, rw_seen, {27'd0, rd_v});
      check_val({tag, ".busW_hold"}, wb_busW, exp_v);
   endtask

   initial begin
      int late_done;
      total_cnt = 0;
      bad_cnt   = 0;
      reset = 1'b1;
      start = 1'b0;
      op    = 3'b000;
      rd    = 5'd0;
      busA  = 32'h0;
      busB  = 32'h0;

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst.busy", {31'd0, busy}, 32'd0);
      check_val("rst.done", {31'd0, done}, 32'd0);
      check_val("rst.regwr", {31'd0, wb_RegWr}, 32'd0);
      check_val("rst.Rw", {27'd0, wb_Rw}, 32'd0);
      check_val("rst.busW", wb_busW, 32'd0);
      reset = 1'b0;

      // Unsigned multiply / divide
      run_op("mul7x6",   3'b000, 32'd7,         32'd6,         5'd5,  32'd42,        0);
      run_op("mulhu_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 0);
      run_op("mul_ff",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0001, 0);
      run_op("divu100",  3'b010, 32'd100,       32'd7,         5'd8,  32'd14,        0);
      run_op("remu100",  3'b011, 32'd100,       32'd7,         5'd10, 32'd2,         0);
      run_op("divu_z",   3'b010, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 0);
      run_op("remu_z",   3'b011, 32'd5,         32'd0,         5'd0,  32'd5,         0);

      // Signed-selected operations; results depend on configuration
`ifdef MULDIV_SIGNED_EN
      run_op("div_m7",   3'b110, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFD, 0);
      run_op("rem_m7",   3'b111, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFF, 0);
      run_op("div_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 0);
      run_op("rem_ovf",  3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 0);
      run_op("mulh_m1",  3'b101, 32'hFFFF_FFFF, 32'd1,         5'd16, 32'hFFFF_FFFF, 0);
      run_op("mul_m3x5", 3'b100, 32'hFFFF_FFFD, 32'd5,         5'd17, 32'hFFFF_FFF1, 0);
`else
      run_op("div_m7",   3'b110, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'h7FFF_FFFC, 0);
      run_op("rem_m7",   3'b111, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'h0000_0001, 0);
      run_op("div_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 0);
      run_op("rem_ovf",  3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
      run_op("mulh_m1",  3'b101, 32'hFFFF_FFFF, 32'd1,         5'd16, 32'h0000_0000, 0);
      run_op("mul_m3x5", 3'b100, 32'hFFFF_FFFD, 32'd5,         5'd17, 32'hFFFF_FFF1, 0);
`endif
      // Divide by zero with the signed bit set: same in both builds
      run_op("div_sz",   3'b110, 32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFFF, 0);
      run_op("rem_sz",   3'b111, 32'hFFFF_FFF9, 32'd0,         5'd19, 32'hFFFF_FFF9, 0);

      // Second start during cycle 10 must be ignored, no further completion
      run_op("busy_start", 3'b000, 32'd1000, 32'd3, 5'd20, 32'd3000, 10);
      late_done = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) late_done++;
      end
      check_val("busy_start.late_done", 32'(late_done), 32'd0);

      // Reset asserted in cycle 12 of an operation
      @(negedge clk);
      start = 1'b1;
      op    = 3'b000;
      busA  = 32'd3;
      busB  = 32'd5;
      rd    = 5'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (12) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_val("mid_rst.busy", {31'd0, busy}, 32'd0);
      check_val("mid_rst.done", {31'd0, done}, 32'd0);
      check_val("mid_rst.regwr", {31'd0, wb_RegWr}, 32'd0);
      check_val("mid_rst.Rw", {27'd0, wb_Rw}, 32'd0);
      check_val("mid_rst.busW", wb_busW, 32'd0);
      reset = 1'b0;
      late_done = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done) late_done++;
      end
      check_val("mid_rst.no_done", 32'(late_done), 32'd0);
      check_val("mid_rst.idle", {31'd0, busy}, 32'd0);

      // Unit still works after the aborted operation
      run_op("post_rst", 3'b011, 32'd1000, 32'd7, 5'd21, 32'd6, 0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
